// File: rtl/saturn_serial_tx.sv
// saturn_serial_tx -- debug-serial UART 8N1 transmitter.
//
// Takes the character stream from the bus controller's debug outputs and
// queues it in a small FIFO. Characters leave LSB first on o_tx, framed as
// start(0) + 8 data bits + stop(1), each bit lasting BAUD_DIV clocks.
// When another byte is queued at the end of a stop bit, its start bit follows
// with no idle gap. The block runs on the raw clock.
//
// Parameters:
//   BAUD_DIV  clocks per serial bit (>= 2)
//   FIFO_AW   FIFO address width; depth = 2**FIFO_AW
//
// Ports:
//   i_clk, i_reset_n    clock, asynchronous active-low reset
//   i_char_to_send      byte to queue
//   i_char_valid        i_char_to_send is valid
//   i_char_send         single-cycle write strobe
//   o_serial_busy       FIFO full; writes are dropped while high
//   o_tx                UART line, idle high
//   o_fifo_level        bytes stored in the FIFO (not the one in the shifter)
//   o_idle              FIFO empty and transmitter idle
//
// Optional feature macro: SATURN_SERIAL_TX_CRLF_EN
//   When defined, each LF (0x0A) is sent as CR (0x0D) followed by LF.
//   The CR is generated on the fly and never occupies a FIFO slot.

module saturn_serial_tx #(
  parameter int BAUD_DIV = 104,
  parameter int FIFO_AW  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [7:0]         i_char_to_send,
  input  logic               i_char_valid,
  input  logic               i_char_send,
  output logic               o_serial_busy,
  output logic               o_tx,
  output logic [FIFO_AW:0]   o_fifo_level,
  output logic               o_idle
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               busy_q, busy_d;
  logic [7:0]         mem [DEPTH];

  logic               empty;
  logic               wr_en;
  logic               baud_end;
  logic               load;
  logic               pop;
  logic [7:0]         head;
  logic [7:0]         load_byte;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign wr_en    = i_char_send && i_char_valid && !busy_q;
  assign baud_end = (cnt_q == CW'(BAUD_DIV - 1));
  assign head     = mem[rd_ptr_q[FIFO_AW-1:0]];

  // A new byte enters the shifter either from IDLE or straight out of the
  // stop bit, which is what makes back-to-back frames gapless.
  assign load = !empty && ((state_q == S_IDLE) ||
                           (state_q == S_STOP && baud_end));

`ifdef SATURN_SERIAL_TX_CRLF_EN
  logic cr_done_q;
  logic ins_cr;

  // An LF at the head is first sent as CR while it stays in the FIFO; the
  // following load pops the LF itself.
  assign ins_cr    = load && (head == 8'h0A) && !cr_done_q;
  assign pop       = load && !ins_cr;
  assign load_byte = ins_cr ? 8'h0D : head;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  cr_done_q <= 1'b0;
    else if (ins_cr) cr_done_q <= 1'b1;
    else if (pop)    cr_done_q <= 1'b0;
  end
`else
  assign pop       = load;
  assign load_byte = head;
`endif

  // FIFO pointers carry one extra wrap bit; full is "same slot, other lap".
  assign wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
  assign rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
  assign busy_d   = (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
                    (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= i_char_to_send;
  end

  // State register and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_START;
      S_START: if (baud_end) state_d = S_DATA;
      S_DATA:  if (baud_end && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_end) state_d = load ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic; o_tx is registered so each line level is set on
  // the edge that enters the bit it belongs to.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (load) begin
          shift_d = load_byte;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          cnt_d = '0;
          bit_d = 3'd0;
          tx_d  = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (load) begin
            shift_d = load_byte;
            tx_d    = 1'b0;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
    endcase
  end

  assign o_tx          = tx_q;
  assign o_serial_busy = busy_q;
  assign o_fifo_level  = wr_ptr_q - rd_ptr_q;
  assign o_idle        = (state_q == S_IDLE) && empty;

endmodule

// File: tb/tb_saturn_serial_tx.sv
module tb_saturn_serial_tx;
  localparam int BD = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ch = 8'h00;
  logic          vld = 1'b0;
  logic          snd = 1'b0;
  logic          busy, tx, idle;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  saturn_serial_tx #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_char_to_send (ch),
    .i_char_valid   (vld),
    .i_char_send    (snd),
    .o_serial_busy  (busy),
    .o_tx           (tx),
    .o_fifo_level   (level),
    .o_idle         (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge showing the first start-bit cycle; returns on the
  // negedge showing the last stop-bit cycle.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10*BD; k++) begin
      if (k > 0) @(negedge clk);
      chk(tag, {31'd0, tx}, {31'd0, f[k/BD]});
    end
  endtask

  // Waits (bounded) for a start bit, samples mid-bit, returns on the last
  // stop-bit cycle.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int n;
    logic stp;
    n = 0;
    b = 8'h00;
    stp = 1'b0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      ok = 1'b0;
    end else begin
      for (int k = 1; k < 10*BD; k++) begin
        @(negedge clk);
        if (k % BD == BD/2) begin
          if (k / BD >= 1 && k / BD <= 8) b[k/BD - 1] = tx;
          if (k / BD == 9) stp = tx;
        end
      end
      ok = stp;
    end
  endtask

  task automatic wr1(input logic [7:0] d);
    @(negedge clk);
    ch = d; vld = 1'b1; snd = 1'b1;
    @(negedge clk);
    snd = 1'b0; vld = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       ok;
    int         lows;
    int         bad;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, tx},   32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_idle",  {31'd0, idle}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single 0x55 frame, one-cycle latency to the start bit
    wr1(8'h55);
    chk("t1_tx_before_pop", {31'd0, tx}, 32'd1);
    chk("t1_level_queued",  {27'd0, level}, 32'd1);
    chk("t1_not_idle",      {31'd0, idle}, 32'd0);
    @(negedge clk);
    check_frame(8'h55, "t1_frame55");
    @(negedge clk);
    chk("t1_idle_after", {31'd0, idle}, 32'd1);

    // 2: back-to-back 0x41, 0x42 with no gap
    @(negedge clk);
    ch = 8'h41; vld = 1'b1; snd = 1'b1;
    @(negedge clk);
    ch = 8'h42;
    @(negedge clk);
    snd = 1'b0; vld = 1'b0;
    check_frame(8'h41, "t2_frame41");
    @(negedge clk);
    check_frame(8'h42, "t2_frame42");
    @(negedge clk);
    chk("t2_idle_after", {31'd0, idle}, 32'd1);

    // 3: fill the FIFO, 0x11 dropped
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("t3_level15", {27'd0, level}, 32'd15);
        chk("t3_busy_lo", {31'd0, busy}, 32'd0);
      end
      if (i == 17) begin
        chk("t3_level16", {27'd0, level}, 32'd16);
        chk("t3_busy_hi", {31'd0, busy}, 32'd1);
      end
      ch = 8'(i); vld = 1'b1; snd = 1'b1;
    end
    @(negedge clk);
    snd = 1'b0; vld = 1'b0;
    chk("t3_level_after_drop", {27'd0, level}, 32'd16);
    chk("t3_busy_after_drop",  {31'd0, busy}, 32'd1);
    repeat (23) @(negedge clk);
    for (int j = 1; j <= 16; j++) begin
      rx_byte(rb, ok);
      chk("t3_rx_byte", {23'd0, ok, rb}, {23'd0, 1'b1, 8'(j)});
      if (j == 1) begin
        chk("t3_level_drain", {27'd0, level}, 32'd15);
        chk("t3_busy_drain",  {31'd0, busy}, 32'd0);
      end
    end
    @(negedge clk);
    chk("t3_idle_end",  {31'd0, idle}, 32'd1);
    chk("t3_level_end", {27'd0, level}, 32'd0);

    // 4: strobe without valid is ignored
    @(negedge clk);
    ch = 8'h7F; vld = 1'b0; snd = 1'b1;
    @(negedge clk);
    snd = 1'b0;
    chk("t4_level", {27'd0, level}, 32'd0);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("t4_no_frame", lows, 32'd0);
    chk("t4_idle", {31'd0, idle}, 32'd1);

    // 5: reset during data bit 3 with 5 bytes queued
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ch = (i == 0) ? 8'hF0 : 8'(8'h20 + i); vld = 1'b1; snd = 1'b1;
    end
    @(negedge clk);
    snd = 1'b0; vld = 1'b0;
    repeat (13) @(negedge clk);
    chk("t5_bit3_low", {31'd0, tx}, 32'd0);
    chk("t5_level5",   {27'd0, level}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tx",  {31'd0, tx}, 32'd1);
    chk("t5_rst_level", {27'd0, level}, 32'd0);
    chk("t5_rst_idle",  {31'd0, idle}, 32'd1);
    chk("t5_rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || level !== '0 || idle !== 1'b1) bad++;
    end
    chk("t5_quiet_after_reset", bad, 32'd0);

    // 6: LF handling
    wr1(8'h0A);
    @(negedge clk);
`ifdef SATURN_SERIAL_TX_CRLF_EN
    chk("t6_lf_still_queued", {27'd0, level}, 32'd1);
    check_frame(8'h0D, "t6_frame_cr");
    @(negedge clk);
    check_frame(8'h0A, "t6_frame_lf");
`else
    chk("t6_lf_popped", {27'd0, level}, 32'd0);
    check_frame(8'h0A, "t6_frame_lf");
`endif
    @(negedge clk);
    chk("t6_idle_end", {31'd0, idle}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
